// File: rtl/im_bootloader_pkg.sv
// Shared types and defaults for the instruction-memory bootloader.
// Frame: SYNC, LEN_HI, LEN_LO, N little-endian words, 8-bit additive checksum.
package im_boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } boot_state_t;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
   localparam int         DEF_MAX_WORDS = 8192;

endpackage

// File: rtl/im_bootloader.sv
// Assembles a UART byte stream into instruction words and writes them to
// instruction memory, releasing the CPU only after a checksum-verified image.
module im_bootloader
   import im_boot_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter int         ADDR_W    = 13,
   parameter int         MAX_WORDS = DEF_MAX_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_vld,
   input  logic [7:0]        rx_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              cpu_hold,
   output logic              boot_done,
   output logic              boot_err
);

   boot_state_t       state;
   logic [15:0]       len;
   logic [1:0]        byte_idx;
   logic [23:0]       word_sh;
   logic [7:0]        sum;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   word_cnt_nxt;
   logic [15:0]       len_rx;

   // A legal image holds between one and MAX_WORDS words.
   function automatic logic len_ok(input logic [15:0] n);
      return (n != 16'd0) && (32'(n) <= 32'(MAX_WORDS));
   endfunction

   assign word_cnt_nxt = word_cnt + 1'b1;
   assign len_rx       = {len[15:8], rx_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len       <= '0;
         byte_idx  <= '0;
         word_sh   <= '0;
         sum       <= '0;
         word_cnt  <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         cpu_hold  <= 1'b1;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
      end else begin
         we <= 1'b0;
         if (rx_vld) begin
            unique case (state)
               IDLE, ERR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state    <= LEN_HI;
                     boot_err <= 1'b0;
                     sum      <= '0;
                     word_cnt <= '0;
                  end
               end
               LEN_HI: begin
                  len[15:8] <= rx_data;
                  state     <= LEN_LO;
               end
               LEN_LO: begin
                  len[7:0] <= rx_data;
                  byte_idx <= '0;
                  if (len_ok(len_rx)) begin
                     state <= DATA;
                  end else begin
                     state    <= ERR;
                     boot_err <= 1'b1;
                  end
               end
               DATA: begin
                  sum      <= sum + rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0:    word_sh[7:0]   <= rx_data;
                     2'd1:    word_sh[15:8]  <= rx_data;
                     2'd2:    word_sh[23:16] <= rx_data;
                     default: begin
                        // Final byte goes straight into wdata, so the next
                        // word may start assembling on the very next cycle.
                        we       <= 1'b1;
                        waddr    <= word_cnt[ADDR_W-1:0];
                        wdata    <= {rx_data, word_sh};
                        word_cnt <= word_cnt_nxt;
                        if (32'(word_cnt_nxt) == 32'(len)) begin
                           state <= CHK;
                        end
                     end
                  endcase
               end
               CHK: begin
                  if (rx_data == sum) begin
                     state     <= DONE;
                     boot_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state    <= ERR;
                     boot_err <= 1'b1;
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/im_bootloader.md
Name: im_bootloader

Overview:
- Upstream feeder of the instruction memory's write port.
- Receives a byte stream from the UART receiver and assembles little-endian 32-bit words. Drives one-cycle write strobes with sequential word addresses into instruction memory.
- Holds the CPU in reset until a complete image with a valid checksum has been loaded.
- Outputs are registered on posedge clk, so they are stable at the memory's negedge write.

Parameters:
- SYNC_BYTE, 8'hA5, byte that starts a boot transfer.
- ADDR_W, 13, instruction-memory word-address width.
- MAX_WORDS, 8192, largest legal image size in words (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_vld  input  1  single-cycle strobe: rx_data holds a new received byte.
- rx_data  input  8  received byte.
- we  output  1  instruction-memory write enable, one-cycle pulse per word.
- waddr  output  ADDR_W  instruction-memory word address.
- wdata  output  32  assembled instruction word.
- cpu_hold  output  1  1 = CPU held in reset (also gates instruction reads).
- boot_done  output  1  sticky; image loaded and checksum matched.
- boot_err  output  1  sticky until next sync; length or checksum error.

Behaviour:
- Reset values: we=0, waddr=0, wdata=0, cpu_hold=1, boot_done=0, boot_err=0, state=IDLE, all counters=0.
- Frame format, in order:
  - SYNC_BYTE
  - LEN_HI, then LEN_LO: 16-bit word count N, big-endian
  - N×4 data bytes, each word little-endian (first byte goes to wdata[7:0])
  - CHK: 8-bit modulo-256 sum of all data bytes
- Bytes are consumed only in cycles with rx_vld=1. Cycles without rx_vld leave all state unchanged.
- States and transitions:
  - IDLE: rx_vld && rx_data==SYNC_BYTE -> LEN_HI. Clear boot_err, sum, and word counter. Any other byte is ignored.
  - LEN_HI: on rx_vld, latch len[15:8] -> LEN_LO.
  - LEN_LO: on rx_vld, latch len[7:0].
    - If the full length is 0 or exceeds MAX_WORDS -> ERR.
    - Otherwise -> DATA with byte_idx=0.
  - DATA: on rx_vld, write the byte into lane byte_idx of the word shift register, add it to sum, and increment byte_idx (2 bits).
    - On byte_idx==3: in the next cycle, wdata = assembled word, waddr = word_cnt, we=1 for exactly one cycle; word_cnt increments.
    - After word N-1 is written -> CHK.
  - CHK: on rx_vld:
    - rx_data==sum -> DONE.
    - Otherwise -> ERR.
  - DONE: boot_done=1 and cpu_hold=0 from the cycle after the CHK byte. Terminal until rst; further bytes are ignored, including SYNC_BYTE.
  - ERR: boot_err=1, cpu_hold stays 1, we never asserts. Behaves as IDLE: the next SYNC_BYTE restarts the frame and clears boot_err.
- Write timing:
  - we latency is 1 cycle after the rx_vld of the 4th byte of each word.
  - waddr and wdata are stable while we=1 and hold their values afterwards.
  - A back-to-back rx_vld on the next byte does not corrupt the pending word: the word register is copied to wdata before it is overwritten.
- Addressing: word_cnt is ADDR_W+1 bits wide so that N=MAX_WORDS is legal. waddr = word_cnt[ADDR_W-1:0]; it never wraps within a legal frame.
- Checksum: sum is 8 bits and wraps modulo 256. Only data bytes are summed; SYNC, LEN, and CHK are excluded.
- A sync byte value appearing inside LEN or DATA is treated as data, with no resynchronisation.
- rst in any state, including mid-word, returns everything to the reset values.
  - Memory contents already written are not cleared.
  - Any partial word is dropped.

Decomposition:
- Package im_boot_pkg holds:
  - state enum typedef {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR}
  - localparam SYNC_BYTE default
  - localparam MAX_WORDS
- Single module; no sub-module is needed. The byte-to-word assembler is a few lines inside the DATA state.

Test Plan:
- A5 00 01 | 13 00 00 00 | 13 -> one we pulse with waddr=0, wdata=32'h00000013; then boot_done=1, cpu_hold=0, boot_err=0.
- A5 00 02, words 32'h00500093 and 32'h00A00113 sent little-endian, rx_vld every cycle, correct CHK:
  - we at waddr 0 then 1 with matching wdata.
  - Each we lasts exactly 1 cycle.
  - done follows.
- Same 1-word frame with CHK=8'h14 -> boot_err=1, cpu_hold=1, boot_done=0. Then a correct frame -> boot_err clears and boot_done=1.
- Length errors: A5 00 00 -> ERR with no we. A5 20 01 (8193) -> ERR. A5 20 00 with 8192 words -> last we at waddr=13'h1FFF, then done.
- rst asserted after 2 data bytes, then a full valid 1-word frame -> outputs at reset values after rst; the new frame writes waddr=0 correctly.
- Noise bytes 00 FF before A5, plus idle gaps of 0-5 cycles between rx_vld strobes -> identical we/waddr/wdata sequence to the gap-free run.
